uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo.sv | 46 ++++
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter.
// Frame sequencer states and parity-mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

endpackage

// File: rtl/uart_fifo.sv
// Transmit buffer: power-of-two circular FIFO.
// Extra pointer bit separates full from empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr;
  logic             rd;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];
  assign wr    = push && !full;
  assign rd    = pop && !empty;

  always_ff @(posedge clock) begin
    if (wr) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a frame sequencer.
// Line settings are captured per frame at the pop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          clock_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_overflow
);

  tx_state_t            state;
  tx_state_t            state_d;
  logic [15:0]          baud_cnt;
  logic [15:0]          baud_d;
  logic [15:0]          div_q;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_d;
  logic [3:0]           stop_last;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;
  logic [DATA_BITS-1:0] rdata;
  logic                 par_en_q;
  logic                 par_q;
  logic                 two_q;
  logic                 tx_d;
  logic                 done_d;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 bit_end;

  assign push      = tx_ready && !tx_full;
  assign bit_end   = baud_cnt == div_q - 16'd1;
  assign stop_last = {3'b000, two_q};
  assign tx_busy   = (state != IDLE) || !empty;

  uart_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(tx_data),
    .rdata(rdata),
    .full(tx_full),
    .empty(empty)
  );

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt + 16'd1;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    tx_d    = tx;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          shreg_d = rdata;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shreg[0];
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = shreg >> 1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_cnt + 4'd1;
            tx_d  = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_cnt == stop_last) begin
            // Chain straight into the next frame when data is waiting.
            done_d = 1'b1;
            bit_d  = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
              shreg_d = rdata;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_cnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx          <= 1'b1;
      tx_done     <= 1'b0;
      tx_overflow <= 1'b0;
      div_q       <= 16'd1;
      par_en_q    <= 1'b0;
      par_q       <= 1'b0;
      two_q       <= 1'b0;
    end else begin
      state       <= state_d;
      baud_cnt    <= baud_d;
      bit_cnt     <= bit_d;
      shreg       <= shreg_d;
      tx          <= tx_d;
      tx_done     <= done_d;
      tx_overflow <= tx_ready && tx_full;
      if (pop) begin
        div_q    <= (clock_div == 16'd0) ? 16'd1 : clock_div;
        two_q    <= two_stop;
        par_en_q <= (parity_mode == PARITY_EVEN) ||
                    (parity_mode == PARITY_ODD);
        par_q    <= (^rdata) ^ (parity_mode == PARITY_ODD);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo.
// Line activity is logged per cycle and frames are checked bit by bit.
module tb_uart_tx_fifo;

  localparam int MAXC = 8192;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] clock_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx;
  logic        tx_done;
  logic        tx_busy;
  logic        tx_full;
  logic        tx_overflow;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   ov_cnt   = 0;
  logic txlog   [MAXC];
  logic donelog [MAXC];

  logic [7:0]  bd [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  rx;
  logic [31:0] word;
  int          s0, s, n, d0, o0, r0, bad;

  uart_tx_fifo #(
    .DATA_BITS(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .clock_div(clock_div),
    .parity_mode(parity_mode),
    .two_stop(two_stop),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx(tx),
    .tx_done(tx_done),
    .tx_busy(tx_busy),
    .tx_full(tx_full),
    .tx_overflow(tx_overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cyc < MAXC) begin
      txlog[cyc]   <= tx;
      donelog[cyc] <= tx_done;
    end
    cyc <= cyc + 1;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_overflow === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_cyc(input int idx);
    int g = 0;
    while (cyc <= idx && g < 3000) begin
      @(negedge clock);
      #1;
      g++;
    end
    if (cyc <= idx || idx >= MAXC) begin
      failures++;
      $display("FAIL timeout observed=%0d expected=%0d", cyc, idx);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench timed out");
    end
  endtask

  task automatic write1(input logic [7:0] d);
    tx_data  = d;
    tx_ready = 1'b1;
    @(negedge clock);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic find_start(input string tag, input int from,
                            input int maxw, output int idx);
    idx = -1;
    for (int k = from; k <= from + maxw && idx < 0; k++) begin
      wait_cyc(k);
      if (txlog[k] === 1'b0) idx = k;
    end
    chk({tag, " start"}, 32'(idx >= 0), 32'd1);
    if (idx < 0) idx = from;
  endtask

  task automatic check_frame(input string tag, input int st,
                             input logic [7:0] d, input int div,
                             input int pm, input int stops,
                             output logic [7:0] got, output int nxt);
    logic want [12];
    int   eff, nb, pos, b_bad;
    eff = (div == 0) ? 1 : div;
    want[0] = 1'b0;
    for (int i = 0; i < 8; i++) want[1 + i] = d[i];
    nb = 9;
    if (pm == 1) begin
      want[nb] = ^d;
      nb++;
    end else if (pm == 2) begin
      want[nb] = ~^d;
      nb++;
    end
    want[nb] = 1'b1;
    nb++;
    if (stops == 2) begin
      want[nb] = 1'b1;
      nb++;
    end
    got = '0;
    pos = st;
    for (int b = 0; b < nb; b++) begin
      wait_cyc(pos + eff - 1);
      b_bad = 0;
      for (int c = 0; c < eff; c++) begin
        if (txlog[pos + c] !== want[b]) b_bad++;
        if (b > 0 && donelog[pos + c] !== 1'b0) b_bad++;
      end
      if (b >= 1 && b <= 8) got[b - 1] = txlog[pos];
      chk($sformatf("%s bit%0d", tag, b), b_bad, 0);
      pos += eff;
    end
    wait_cyc(pos);
    chk({tag, " done"}, {31'd0, donelog[pos]}, 32'd1);
    nxt = pos;
  endtask

  initial begin
    reset       = 1'b1;
    clock_div   = 16'd4;
    parity_mode = 2'd0;
    two_stop    = 1'b0;
    tx_data     = '0;
    tx_ready    = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_full", {31'd0, tx_full}, 32'd0);
    chk("rst_ovf", {31'd0, tx_overflow}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("idle_tx", {31'd0, tx}, 32'd1);
    chk("idle_busy", {31'd0, tx_busy}, 32'd0);

    // single 0x41 frame, 4-cycle bits
    s0 = cyc;
    d0 = done_cnt;
    write1(8'h41);
    chk("single_busy", {31'd0, tx_busy}, 32'd1);
    find_start("single", s0, 20, s);
    check_frame("single", s, 8'h41, 4, 0, 1, rx, n);
    chk("single_rx", rx, 8'h41);
    chk("single_cnt", done_cnt - d0, 1);
    chk("single_idle", {31'd0, tx_busy}, 32'd0);

    // even then odd parity on 0x44
    parity_mode = 2'd1;
    s0 = cyc;
    write1(8'h44);
    find_start("even", s0, 20, s);
    check_frame("even", s, 8'h44, 4, 1, 1, rx, n);
    parity_mode = 2'd2;
    s0 = cyc;
    write1(8'h44);
    find_start("odd", s0, 20, s);
    check_frame("odd", s, 8'h44, 4, 2, 1, rx, n);
    parity_mode = 2'd0;

    // four consecutive writes, frames chained with no gap
    s0 = cyc;
    d0 = done_cnt;
    tx_ready = 1'b1;
    tx_data = 8'h41; @(negedge clock); #1;
    tx_data = 8'h44; @(negedge clock); #1;
    tx_data = 8'h41; @(negedge clock); #1;
    tx_data = 8'h4D; @(negedge clock); #1;
    tx_ready = 1'b0;
    find_start("adam", s0, 20, s);
    check_frame("adam0", s, 8'h41, 4, 0, 1, rx, n);
    word[31:24] = rx;
    check_frame("adam1", n, 8'h44, 4, 0, 1, rx, n);
    word[23:16] = rx;
    check_frame("adam2", n, 8'h41, 4, 0, 1, rx, n);
    word[15:8] = rx;
    check_frame("adam3", n, 8'h4D, 4, 0, 1, rx, n);
    word[7:0] = rx;
    chk("adam_word", word, 32'h4144414D);
    chk("adam_cnt", done_cnt - d0, 4);

    // overflow: fill the buffer while a slow frame runs
    clock_div = 16'd8;
    s0 = cyc;
    d0 = done_cnt;
    o0 = ov_cnt;
    write1(8'h11);
    find_start("ovf", s0, 20, s);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = bd[i];
      @(negedge clock);
      #1;
      if (i == 3) begin
        chk("ovf_full", {31'd0, tx_full}, 32'd1);
        chk("ovf_quiet", {31'd0, tx_overflow}, 32'd0);
      end
    end
    tx_ready = 1'b0;
    chk("ovf_pulse", {31'd0, tx_overflow}, 32'd1);
    @(negedge clock);
    #1;
    chk("ovf_clear", {31'd0, tx_overflow}, 32'd0);
    chk("ovf_still_full", {31'd0, tx_full}, 32'd1);
    check_frame("ovf0", s, 8'h11, 8, 0, 1, rx, n);
    for (int i = 0; i < 4; i++) begin
      check_frame($sformatf("ovf%0d", i + 1), n, bd[i], 8, 0, 1, rx, n);
      chk($sformatf("ovf%0d_rx", i + 1), rx, bd[i]);
    end
    chk("ovf_cnt", ov_cnt - o0, 1);
    chk("ovf_frames", done_cnt - d0, 5);
    chk("ovf_idle", {31'd0, tx_busy}, 32'd0);
    chk("ovf_empty", {31'd0, tx_full}, 32'd0);

    // divider 0 behaves as 1; parity mode 3 means none
    clock_div = 16'd0;
    parity_mode = 2'd3;
    s0 = cyc;
    write1(8'hA5);
    find_start("div0", s0, 20, s);
    check_frame("div0", s, 8'hA5, 0, 3, 1, rx, n);
    parity_mode = 2'd0;

    // settings changed mid-frame apply only to the next frame
    clock_div = 16'd4;
    two_stop = 1'b0;
    s0 = cyc;
    tx_ready = 1'b1;
    tx_data = 8'h0F; @(negedge clock); #1;
    tx_data = 8'hF0; @(negedge clock); #1;
    tx_ready = 1'b0;
    clock_div = 16'd8;
    two_stop = 1'b1;
    find_start("cfg", s0, 20, s);
    check_frame("cfg_a", s, 8'h0F, 4, 0, 1, rx, n);
    check_frame("cfg_b", n, 8'hF0, 8, 0, 2, rx, n);
    chk("cfg_b_rx", rx, 8'hF0);

    // reset during data bits aborts and drops buffered data
    clock_div = 16'd4;
    two_stop = 1'b0;
    s0 = cyc;
    tx_ready = 1'b1;
    tx_data = 8'h5A; @(negedge clock); #1;
    tx_data = 8'h3C; @(negedge clock); #1;
    tx_ready = 1'b0;
    find_start("rst", s0, 20, s);
    wait_cyc(s + 12);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_mid_full", {31'd0, tx_full}, 32'd0);
    d0 = done_cnt;
    r0 = cyc;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    wait_cyc(r0 + 20);
    bad = 0;
    for (int k = r0; k <= r0 + 20; k++) begin
      if (txlog[k] !== 1'b1) bad++;
      if (donelog[k] !== 1'b0) bad++;
    end
    chk("rst_quiet", bad, 0);
    chk("rst_no_done", done_cnt - d0, 0);
    s0 = cyc;
    write1(8'h96);
    find_start("after_rst", s0, 20, s);
    check_frame("after_rst", s, 8'h96, 4, 0, 1, rx, n);
    chk("after_rst_rx", rx, 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
